// File: rtl/register_file.sv
// MIPS-style register file: two combinational read ports, one clocked write port,
// saturating committed-write counter. Define WRITE_BYPASS_EN for same-cycle write-to-read bypass.
module register_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic [CNT_W-1:0]  wr_count
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              wr_en;

   // Writes to r0 are dropped entirely, so r0 never leaves its reset value
   assign wr_en = reg_write && (write_reg != '0) && !rst;

   always_comb begin
      cnt_d = cnt_q;
      if (wr_en && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q <= '{default: '0};
         cnt_q  <= '0;
      end else begin
         if (wr_en) begin
            regs_q[write_reg] <= write_data;
         end
         cnt_q <= cnt_d;
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] val;
      val = '0;
      if (!rst && (addr != '0)) begin
         val = regs_q[addr];
`ifdef WRITE_BYPASS_EN
         if (wr_en && (write_reg == addr)) begin
            val = write_data;
         end
`endif
      end
      return val;
   endfunction

   always_comb begin
      read_data1 = read_port(read_reg1);
   end

   always_comb begin
      read_data2 = read_port(read_reg2);
   end

   assign wr_count = cnt_q;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected values, a negedge monitor checks them.
module tb_register_file;

   logic        clk;
   logic        rst;
   logic        reg_write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [4:0]  read_reg1;
   logic [4:0]  read_reg2;
   logic [31:0] read_data1;
   logic [31:0] read_data2;
   logic [15:0] wr_count;
   logic [31:0] sat_rd1;
   logic [31:0] sat_rd2;
   logic [3:0]  sat_cnt;

`ifdef WRITE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   register_file #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .reg_write(reg_write), .write_reg(write_reg),
      .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .read_data1(read_data1), .read_data2(read_data2), .wr_count(wr_count)
   );

   register_file #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .reg_write(reg_write), .write_reg(write_reg),
      .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .read_data1(sat_rd1), .read_data2(sat_rd2), .wr_count(sat_cnt)
   );

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } chk_t;

   chk_t sbq[$];
   int   n_checks = 0;
   int   n_errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_val(input string n, input int s, input logic [31:0] v);
      chk_t c;
      c.name = n;
      c.sel  = s;
      c.exp  = v;
      sbq.push_back(c);
   endtask

   function automatic logic [31:0] observe(input int s);
      case (s)
         0:       return read_data1;
         1:       return read_data2;
         2:       return {16'h0, wr_count};
         3:       return sat_rd1;
         4:       return sat_rd2;
         default: return {28'h0, sat_cnt};
      endcase
   endfunction

   always @(negedge clk) begin
      while (sbq.size() > 0) begin
         chk_t c;
         logic [31:0] act;
         c   = sbq.pop_front();
         act = observe(c.sel);
         n_checks++;
         if (act !== c.exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
      read_reg1 = 5'd5; read_reg2 = 5'd0;
      step(); step();
      expect_val("reset_rd1", 0, 32'h0);
      expect_val("reset_cnt", 2, 32'h0);
      step();
      rst = 1'b0;

      // r5 = DEADBEEF, bypass visibility before the edge
      reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEADBEEF;
      expect_val("r5_pre_edge", 0, BYPASS ? 32'hDEADBEEF : 32'h0);
      step();
      reg_write = 1'b0;
      expect_val("r5_post_edge", 0, 32'hDEADBEEF);
      expect_val("cnt_after_r5", 2, 32'd1);
      step();

      // Mid-run async reset with a write in flight
      rst = 1'b1;
      reg_write = 1'b1; write_reg = 5'd5; write_data = 32'h11111111;
      expect_val("rst_immediate_rd1", 0, 32'h0);
      expect_val("rst_immediate_cnt", 2, 32'h0);
      step();
      expect_val("rst_edge_rd1", 0, 32'h0);
      expect_val("rst_edge_cnt", 2, 32'h0);
      step();
      rst = 1'b0; reg_write = 1'b0;
      expect_val("after_rst_r5", 0, 32'h0);
      expect_val("after_rst_cnt", 2, 32'h0);
      step();

      // r1 and r31 on successive edges
      reg_write = 1'b1; write_reg = 5'd1; write_data = 32'h00000001;
      step();
      write_reg = 5'd31; write_data = 32'hFFFFFFFF;
      step();
      reg_write = 1'b0; read_reg1 = 5'd1; read_reg2 = 5'd31;
      expect_val("r1", 0, 32'h00000001);
      expect_val("r31", 1, 32'hFFFFFFFF);
      expect_val("cnt_two", 2, 32'd2);
      step();

      // Write to r0 is dropped, bypass included
      read_reg1 = 5'd0; read_reg2 = 5'd0;
      reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h12345678;
      expect_val("r0_pre_p1", 0, 32'h0);
      expect_val("r0_pre_p2", 1, 32'h0);
      step();
      reg_write = 1'b0;
      expect_val("r0_post", 0, 32'h0);
      expect_val("r0_cnt", 2, 32'd2);
      step();

      // Same-cycle write/read of r2 on both ports
      read_reg1 = 5'd2; read_reg2 = 5'd2;
      reg_write = 1'b1; write_reg = 5'd2; write_data = 32'hA5A5A5A5;
      expect_val("r2_pre_p1", 0, BYPASS ? 32'hA5A5A5A5 : 32'h0);
      expect_val("r2_pre_p2", 1, BYPASS ? 32'hA5A5A5A5 : 32'h0);
      step();
      reg_write = 1'b0;
      expect_val("r2_post_p1", 0, 32'hA5A5A5A5);
      expect_val("r2_post_p2", 1, 32'hA5A5A5A5);
      expect_val("r2_cnt", 2, 32'd3);
      step();

      // reg_write=0 for three edges leaves r3 alone
      reg_write = 1'b1; write_reg = 5'd3; write_data = 32'hCAFEF00D;
      step();
      reg_write = 1'b0; write_data = 32'h0000FFFF; read_reg1 = 5'd3;
      step(); step(); step();
      expect_val("r3_hold", 0, 32'hCAFEF00D);
      expect_val("r3_cnt", 2, 32'd4);
      step();

      // Back-to-back writes to r4: last wins; independent port addresses
      reg_write = 1'b1; write_reg = 5'd4; write_data = 32'h00000011;
      step();
      write_data = 32'h00000022;
      step();
      reg_write = 1'b0; read_reg1 = 5'd4; read_reg2 = 5'd31;
      expect_val("r4_last_wins", 0, 32'h00000022);
      expect_val("r31_other_port", 1, 32'hFFFFFFFF);
      expect_val("b2b_cnt", 2, 32'd6);
      step();

      // Counter saturation: clear, then 20 writes to r7
      rst = 1'b1;
      step();
      rst = 1'b0;
      read_reg1 = 5'd7; read_reg2 = 5'd7;
      reg_write = 1'b1; write_reg = 5'd7;
      for (int i = 0; i < 20; i++) begin
         write_data = 32'd100 + 32'(i);
         step();
         if (i == 14) expect_val("sat_cnt_at_15", 5, 32'd15);
         if (i == 15) expect_val("sat_cnt_held", 5, 32'd15);
      end
      reg_write = 1'b0;
      expect_val("sat_cnt_final", 5, 32'd15);
      expect_val("sat_r7_p1", 3, 32'd119);
      expect_val("sat_r7_p2", 4, 32'd119);
      expect_val("wide_cnt_20", 2, 32'd20);
      expect_val("wide_r7", 0, 32'd119);
      step(); step();

      if (sbq.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: got %0d pending expected 0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
